// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx byte transmitter between NUM_REQ requesters.
// Drives an edge-triggered data_ready, confirms acceptance via sampled, then holds off for a gap.
module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned GAP_CYCLES     = 290000,
   parameter int unsigned ACCEPT_TIMEOUT = 4096
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            grant,
   output logic [DATA_WIDTH-1:0]         tx_data,
   output logic                          tx_data_ready,
   input  logic                          tx_sampled,
   output logic                          busy,
   output logic                          timeout_err
);

   localparam int unsigned PtrW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned TimerMax = (GAP_CYCLES > ACCEPT_TIMEOUT) ? GAP_CYCLES : ACCEPT_TIMEOUT;
   localparam int unsigned TimerW   = $clog2(TimerMax + 1);

   localparam logic [TimerW-1:0] GapLast = TimerW'(GAP_CYCLES - 1);
   localparam logic [TimerW-1:0] AccLast = TimerW'(ACCEPT_TIMEOUT - 1);
   localparam logic [PtrW-1:0]   PtrLast = PtrW'(NUM_REQ - 1);
   localparam logic [PtrW:0]     NumReqW = (PtrW + 1)'(NUM_REQ);

   typedef enum logic [2:0] {
      StIdle,
      StLaunch,
      StWaitAccept,
      StWaitStart,
      StGap
   } state_e;

   state_e                  state_q, state_d;
   logic [PtrW-1:0]         rr_ptr_q, rr_ptr_d;
   logic [TimerW-1:0]       timer_q, timer_d;
   logic [NUM_REQ-1:0]      grant_q, grant_d;
   logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
   logic                    tx_data_ready_q, tx_data_ready_d;
   logic                    busy_q, busy_d;
   logic                    timeout_err_q, timeout_err_d;

   logic [DATA_WIDTH-1:0]   req_bytes [NUM_REQ];
   logic                    found;
   logic [PtrW-1:0]         win_idx;
   logic [PtrW:0]           scan_idx;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign req_bytes[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
   end

   // First set request scanning upward from rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      found    = 1'b0;
      win_idx  = '0;
      scan_idx = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         scan_idx = {1'b0, rr_ptr_q} + (PtrW + 1)'(k);
         if (scan_idx >= NumReqW) begin
            scan_idx = scan_idx - NumReqW;
         end
         if (!found && req[scan_idx[PtrW-1:0]]) begin
            found   = 1'b1;
            win_idx = scan_idx[PtrW-1:0];
         end
      end
   end

   always_comb begin
      state_d         = state_q;
      rr_ptr_d        = rr_ptr_q;
      timer_d         = timer_q;
      grant_d         = '0;
      tx_data_d       = tx_data_q;
      tx_data_ready_d = tx_data_ready_q;
      timeout_err_d   = timeout_err_q;

      unique case (state_q)
         StIdle: begin
            if (found) begin
               tx_data_d         = req_bytes[win_idx];
               grant_d[win_idx]  = 1'b1;
               rr_ptr_d          = (win_idx == PtrLast) ? '0 : win_idx + 1'b1;
               state_d           = StLaunch;
            end
         end
         StLaunch: begin
            tx_data_ready_d = 1'b1;
            timer_d         = '0;
            state_d         = StWaitAccept;
         end
         StWaitAccept: begin
            if (tx_sampled) begin
               state_d = StWaitStart;
            end else if (timer_q == AccLast) begin
               // Byte is dropped; grant is not repeated.
               timeout_err_d   = 1'b1;
               tx_data_ready_d = 1'b0;
               timer_d         = '0;
               state_d         = StGap;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         StWaitStart: begin
            if (!tx_sampled) begin
               tx_data_ready_d = 1'b0;
               timer_d         = '0;
               state_d         = StGap;
            end
         end
         StGap: begin
            if (timer_q == GapLast) begin
               timer_d = '0;
               state_d = StIdle;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: begin
            state_d = StGap;
         end
      endcase

      busy_d = (state_d != StIdle);
   end

   // Reset lands in GAP so a frame left in flight by the unreset transmitter can drain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= StGap;
         rr_ptr_q        <= '0;
         timer_q         <= '0;
         grant_q         <= '0;
         tx_data_q       <= '0;
         tx_data_ready_q <= 1'b0;
         busy_q          <= 1'b1;
         timeout_err_q   <= 1'b0;
      end else begin
         state_q         <= state_d;
         rr_ptr_q        <= rr_ptr_d;
         timer_q         <= timer_d;
         grant_q         <= grant_d;
         tx_data_q       <= tx_data_d;
         tx_data_ready_q <= tx_data_ready_d;
         busy_q          <= busy_d;
         timeout_err_q   <= timeout_err_d;
      end
   end

   assign grant         = grant_q;
   assign tx_data       = tx_data_q;
   assign tx_data_ready = tx_data_ready_q;
   assign busy          = busy_q;
   assign timeout_err   = timeout_err_q;

endmodule
